// File: rtl/carbon_uart_pkg.sv
// Shared UART definitions for CarbonIO serial blocks.
// Holds the receiver state encoding, data width and default bit period.
package carbon_uart_pkg;

   localparam int CARBON_UART_DATA_BITS    = 8;
   localparam int CARBON_UART_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_rx_state_e;

endpackage

// File: rtl/carbon_uart_rx_fifo.sv
// Received-byte buffer: sync FIFO with valid/ready pop side.
// Ports: push_i/data_i write side, valid_o/data_o/ready_i read side,
//        overrun_o pulses when a push is refused because the FIFO is full.
module carbon_uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   input  logic         ready_i,
   output logic         overrun_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          ovr_q;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push_ok;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign pop     = ready_i && !empty;
   // a same-cycle pop frees the slot the push needs
   assign push_ok = push_i && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop)     rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
         ovr_q <= push_i && !push_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

   assign valid_o   = !empty;
   assign data_o    = empty ? '0 : mem_q[rd_q];
   assign overrun_o = ovr_q;

endmodule

// File: rtl/carbon_uart_rx.sv
// UART receiver (8N1, optional even parity via CARBON_UART_RX_PARITY_EN).
// Ports: clk, rst_n, rx_i serial in; rx_valid/rx_data/rx_ready byte stream;
//        overrun, frame_err, parity_err one-cycle error pulses.
module carbon_uart_rx
   import carbon_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CARBON_UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       overrun,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int DW = CARBON_UART_DATA_BITS;
   localparam int IW = $clog2(DW);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

   uart_rx_state_e state_q;
   logic          s1_q;
   logic          s2_q;
   logic          rxs;
   logic [CW-1:0] cnt_q;
   logic [IW-1:0] idx_q;
   logic [DW-1:0] sh_q;
   logic          push_q;
   logic          fe_q;
`ifdef CARBON_UART_RX_PARITY_EN
   logic          bad_q;
   logic          pe_q;
`endif

   assign rxs = s2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         push_q  <= 1'b0;
         fe_q    <= 1'b0;
`ifdef CARBON_UART_RX_PARITY_EN
         bad_q   <= 1'b0;
         pe_q    <= 1'b0;
`endif
      end else begin
         s1_q   <= rx_i;
         s2_q   <= s1_q;
         push_q <= 1'b0;
         fe_q   <= 1'b0;
`ifdef CARBON_UART_RX_PARITY_EN
         pe_q   <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_q <= START;
                  cnt_q   <= '0;
               end
            end
            START: begin
               // re-check mid start bit to reject short glitches
               if (cnt_q == HALF_M1) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  state_q <= rxs ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  sh_q  <= {rxs, sh_q[DW-1:1]};
                  idx_q <= idx_q + IW'(1);
                  if (idx_q == IW'(DW - 1)) begin
`ifdef CARBON_UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`ifdef CARBON_UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  bad_q   <= ^{sh_q, rxs};
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`endif
            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  if (!rxs) begin
                     fe_q    <= 1'b1;
                     state_q <= BREAK;
                  end else begin
`ifdef CARBON_UART_RX_PARITY_EN
                     if (bad_q) pe_q   <= 1'b1;
                     else       push_q <= 1'b1;
`else
                     push_q <= 1'b1;
`endif
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            BREAK: begin
               // one frame_err per low period, then resync on idle
               if (rxs) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CARBON_UART_RX_PARITY_EN
   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif
   assign frame_err = fe_q;

   carbon_uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push_q),
      .data_i    (sh_q),
      .valid_o   (rx_valid),
      .data_o    (rx_data),
      .ready_i   (rx_ready),
      .overrun_o (overrun)
   );

endmodule

// File: tb/tb_carbon_uart_rx.sv
// Self-checking bench for carbon_uart_rx.
// Directed frames plus randomized traffic against a frame-level model.
module tb_carbon_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_i = 1'b1;
   logic       rx_ready = 1'b0;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       overrun;
   logic       frame_err;
   logic       parity_err;

   carbon_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_i       (rx_i),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   int n_ovr = 0;
   int n_fe  = 0;
   int n_pe  = 0;
   int n_vld = 0;
   logic [7:0] got [$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (overrun)    n_ovr++;
         if (frame_err)  n_fe++;
         if (parity_err) n_pe++;
         if (rx_valid)   n_vld++;
         if (rx_valid && rx_ready) got.push_back(rx_data);
      end
   end

   int b_ovr, b_fe, b_pe, b_vld, b_got;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic mark();
      b_ovr = n_ovr;
      b_fe  = n_fe;
      b_pe  = n_pe;
      b_vld = n_vld;
      b_got = got.size();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(input logic v, input int n);
      rx_i = v;
      tick(n);
   endtask

   // even parity: parity bit makes the total count of ones even
   task automatic send(input logic [7:0] d, input logic stop,
                       input logic pflip);
      line(1'b0, CPB);
      for (int i = 0; i < 8; i++) line(d[i], CPB);
`ifdef CARBON_UART_RX_PARITY_EN
      line((^d) ^ pflip, CPB);
`else
      if (pflip) tick(0);
`endif
      line(stop, CPB);
   endtask

   logic [7:0] exp_q [$];
   int         e_fe;
   int         e_pe;
   int         ovr_pred;
   int         occ;
   logic [7:0] five [5];

   initial begin
      // reset state
      tick(3);
      chk("rst_valid", 32'(rx_valid), 0);
      chk("rst_data", 32'(rx_data), 0);
      chk("rst_pulses", 32'({overrun, frame_err, parity_err}), 0);
      rst_n = 1'b1;
      mark();
      tick(1000);
      chk("idle_valid", 32'(n_vld - b_vld), 0);
      chk("idle_pulses", 32'(n_ovr + n_fe + n_pe), 0);

      // single byte, consumer always ready
      rx_ready = 1'b1;
      mark();
      send(8'hA5, 1'b1, 1'b0);
      line(1'b1, CPB);
      chk("a5_count", 32'(got.size() - b_got), 1);
      if (got.size() > b_got) chk("a5_data", 32'(got[b_got]), 32'hA5);
      chk("a5_vld_cycles", 32'(n_vld - b_vld), 1);
      chk("a5_pulses", 32'(n_ovr + n_fe + n_pe - b_ovr - b_fe - b_pe), 0);

      // fill the FIFO with no consumer; 5th byte overruns
      rx_ready = 1'b0;
      mark();
      five = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      occ = 0;
      ovr_pred = 0;
      foreach (five[i]) begin
         if (occ == DEPTH) ovr_pred++;
         else occ++;
         send(five[i], 1'b1, 1'b0);
         line(1'b1, 2 * CPB);
      end
      chk("ovr_count", 32'(n_ovr - b_ovr), 32'(ovr_pred));
      chk("ovr_hold_valid", 32'(rx_valid), 1);
      chk("ovr_hold_data", 32'(rx_data), 32'h12);
      chk("ovr_fe_pe", 32'(n_fe + n_pe - b_fe - b_pe), 0);
      rx_ready = 1'b1;
      tick(10);
      chk("drain_count", 32'(got.size() - b_got), 32'(occ));
      for (int i = 0; i < occ && b_got + i < got.size(); i++)
         chk($sformatf("drain_%0d", i), 32'(got[b_got + i]),
             32'(five[i]));
      chk("drain_empty", 32'(rx_valid), 0);

      // stop bit low then long break, then a clean frame
      mark();
      send(8'h3C, 1'b0, 1'b0);
      line(1'b0, 40 * CPB);
      line(1'b1, 2 * CPB);
      chk("brk_fe_count", 32'(n_fe - b_fe), 1);
      chk("brk_no_byte", 32'(got.size() - b_got), 0);
      send(8'hC3, 1'b1, 1'b0);
      line(1'b1, CPB);
      chk("brk_next_count", 32'(got.size() - b_got), 1);
      if (got.size() > b_got) chk("brk_next_data", 32'(got[b_got]), 32'hC3);
      chk("brk_ovr_pe", 32'(n_ovr + n_pe - b_ovr - b_pe), 0);

      // short low glitch on an idle line
      mark();
      line(1'b0, 4);
      line(1'b1, 3 * CPB);
      chk("glitch_no_byte", 32'(got.size() - b_got), 0);
      chk("glitch_pulses", 32'(n_ovr + n_fe + n_pe - b_ovr - b_fe - b_pe), 0);
      send(8'h5A, 1'b1, 1'b0);
      line(1'b1, CPB);
      chk("glitch_next_count", 32'(got.size() - b_got), 1);
      if (got.size() > b_got) chk("glitch_next_data", 32'(got[b_got]), 32'h5A);

`ifdef CARBON_UART_RX_PARITY_EN
      mark();
      send(8'h07, 1'b1, 1'b0);
      line(1'b1, CPB);
      chk("par_ok_count", 32'(got.size() - b_got), 1);
      if (got.size() > b_got) chk("par_ok_data", 32'(got[b_got]), 32'h07);
      chk("par_ok_pe", 32'(n_pe - b_pe), 0);
      mark();
      send(8'h07, 1'b1, 1'b1);
      line(1'b1, CPB);
      chk("par_bad_pe", 32'(n_pe - b_pe), 1);
      chk("par_bad_no_byte", 32'(got.size() - b_got), 0);
      chk("par_bad_fe_ovr", 32'(n_fe + n_ovr - b_fe - b_ovr), 0);
`endif

      // reset during data bit 4 of 0xFF, with a byte held in the FIFO
      rx_ready = 1'b0;
      send(8'h81, 1'b1, 1'b0);
      line(1'b1, CPB);
      chk("pre_rst_valid", 32'(rx_valid), 1);
      line(1'b0, CPB);
      line(1'b1, 4 * CPB + CPB / 2);
      rst_n = 1'b0;
      tick(2);
      chk("mid_rst_valid", 32'(rx_valid), 0);
      chk("mid_rst_data", 32'(rx_data), 0);
      chk("mid_rst_pulses", 32'({overrun, frame_err, parity_err}), 0);
      rst_n = 1'b1;
      rx_ready = 1'b1;
      mark();
      line(1'b1, 6 * CPB);
      chk("post_rst_no_byte", 32'(got.size() - b_got), 0);
      send(8'h55, 1'b1, 1'b0);
      line(1'b1, CPB);
      chk("post_rst_count", 32'(got.size() - b_got), 1);
      if (got.size() > b_got) chk("post_rst_data", 32'(got[b_got]), 32'h55);
      chk("post_rst_pulses", 32'(n_ovr + n_fe + n_pe - b_ovr - b_fe - b_pe), 0);

      // randomized frames against the frame-level model
      mark();
      e_fe = 0;
      e_pe = 0;
      for (int k = 0; k < 30; k++) begin
         logic [7:0] d;
         logic       st;
         logic       pf;
         d  = 8'($urandom);
         st = ($urandom_range(0, 5) != 0);
         pf = 1'b0;
`ifdef CARBON_UART_RX_PARITY_EN
         pf = ($urandom_range(0, 5) == 0);
`endif
         if (!st)     e_fe++;
         else if (pf) e_pe++;
         else         exp_q.push_back(d);
         send(d, st, pf);
         if (!st) line(1'b0, CPB * $urandom_range(0, 2));
         line(1'b1, CPB * $urandom_range(1, 3));
      end
      chk("rnd_count", 32'(got.size() - b_got), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && b_got + i < got.size(); i++)
         chk($sformatf("rnd_byte_%0d", i), 32'(got[b_got + i]),
             32'(exp_q[i]));
      chk("rnd_fe", 32'(n_fe - b_fe), 32'(e_fe));
      chk("rnd_pe", 32'(n_pe - b_pe), 32'(e_pe));
      chk("rnd_ovr", 32'(n_ovr - b_ovr), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
